// File: rtl/controlador_turnos_tablero.sv
// Turn controller for the 3x3 board game: button debouncing, cursor, move validation, win/draw detection.
// Optional turn timer enabled by defining TURN_TIMEOUT_EN.
`timescale 1ns/1ps
module controlador_turnos_tablero #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int TIMEOUT_CYCLES  = 500000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        boton_mover,
   input  logic        boton_confirmar,
   output logic [3:0]  casilla_sel,
   output logic [17:0] tablero,
   output logic        jugador,
   output logic [3:0]  movimientos,
   output logic [1:0]  ganador,
   output logic        fin_juego,
   output logic        error_ocupada,
   output logic        timeout
);

   typedef enum logic [2:0] {
      ESPERA  = 3'd0,
      VALIDA  = 3'd1,
      ESCRIBE = 3'd2,
      EVALUA  = 3'd3,
      FIN     = 3'd4
   } estado_t;

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

   // Index 0 is KEY0 (move), index 1 is KEY1 (confirm).
   logic [1:0]    botones_s;
   logic [1:0]    sync1_q, sync2_q, nivel_q;
   logic [DW-1:0] cnt_q [2];
   logic [1:0]    acepta_s, ev_s;

   estado_t       estado_q;
   logic [3:0]    casilla_q;
   logic [17:0]   tablero_q;
   logic          jugador_q;
   logic [3:0]    movimientos_q;
   logic [1:0]    ganador_q;
   logic          fin_q;
   logic          error_q;
   logic          ocupada_s;
   logic [1:0]    ganador_d;

`ifdef TURN_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmr_q;
   logic          timeout_q;
`endif

   // Returns the mark code when cells a, b, c hold the same non-empty mark.
   function automatic logic [1:0] linea(input logic [17:0] t, input int a, input int b, input int c);
      logic [1:0] x, y, z;
      x = t[2*a +: 2];
      y = t[2*b +: 2];
      z = t[2*c +: 2];
      if ((x != 2'b00) && (x == y) && (y == z)) begin
         return x;
      end else begin
         return 2'b00;
      end
   endfunction

   function automatic logic [1:0] buscar_ganador(input logic [17:0] t);
      logic [1:0] g;
      g = linea(t, 0, 1, 2);
      if (g == 2'b00) g = linea(t, 3, 4, 5);
      if (g == 2'b00) g = linea(t, 6, 7, 8);
      if (g == 2'b00) g = linea(t, 0, 3, 6);
      if (g == 2'b00) g = linea(t, 1, 4, 7);
      if (g == 2'b00) g = linea(t, 2, 5, 8);
      if (g == 2'b00) g = linea(t, 0, 4, 8);
      if (g == 2'b00) g = linea(t, 2, 4, 6);
      return g;
   endfunction

   assign botones_s = {boton_confirmar, boton_mover};
   assign ocupada_s = (tablero_q[2*casilla_q +: 2] != 2'b00);
   assign ganador_d = buscar_ganador(tablero_q);

   // A level is accepted on the DEBOUNCE_CYCLES-th differing sample; only presses raise an event.
   always_comb begin
      acepta_s = 2'b00;
      ev_s     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         acepta_s[i] = (sync2_q[i] != nivel_q[i]) && (cnt_q[i] == DMAX);
         ev_s[i]     = acepta_s[i] & ~sync2_q[i];
      end
   end

   // Synchronizers and debounce counters for both keys.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= 2'b11;
         sync2_q  <= 2'b11;
         nivel_q  <= 2'b11;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         sync1_q <= botones_s;
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == nivel_q[i]) begin
               cnt_q[i] <= '0;
            end else if (acepta_s[i]) begin
               nivel_q[i] <= sync2_q[i];
               cnt_q[i]   <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Turn FSM with all game outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado_q      <= ESPERA;
         casilla_q     <= 4'd0;
         tablero_q     <= 18'd0;
         jugador_q     <= 1'b0;
         movimientos_q <= 4'd0;
         ganador_q     <= 2'b00;
         fin_q         <= 1'b0;
         error_q       <= 1'b0;
`ifdef TURN_TIMEOUT_EN
         tmr_q         <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         error_q <= 1'b0;
`ifdef TURN_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (estado_q)
            ESPERA: begin
               if (ev_s[1]) begin
                  error_q  <= ocupada_s;
                  estado_q <= VALIDA;
`ifdef TURN_TIMEOUT_EN
                  tmr_q    <= '0;
`endif
               end else if (ev_s[0]) begin
                  casilla_q <= (casilla_q == 4'd8) ? 4'd0 : casilla_q + 4'd1;
`ifdef TURN_TIMEOUT_EN
                  tmr_q     <= '0;
               end else if (tmr_q == TMAX) begin
                  timeout_q <= 1'b1;
                  jugador_q <= ~jugador_q;
                  tmr_q     <= '0;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
`endif
               end
            end
            VALIDA: begin
`ifdef TURN_TIMEOUT_EN
               tmr_q <= '0;
`endif
               if (ocupada_s) begin
                  estado_q <= ESPERA;
               end else begin
                  tablero_q[2*casilla_q +: 2] <= {jugador_q, ~jugador_q};
                  movimientos_q               <= movimientos_q + 4'd1;
                  estado_q                    <= ESCRIBE;
               end
            end
            // The mark is already in tablero_q here, so the result is decided one cycle after the write.
            ESCRIBE: begin
`ifdef TURN_TIMEOUT_EN
               tmr_q <= '0;
`endif
               if (ganador_d != 2'b00) begin
                  ganador_q <= ganador_d;
                  fin_q     <= 1'b1;
               end else if (movimientos_q == 4'd9) begin
                  ganador_q <= 2'b11;
                  fin_q     <= 1'b1;
               end else begin
                  jugador_q <= ~jugador_q;
               end
               estado_q <= EVALUA;
            end
            EVALUA: begin
`ifdef TURN_TIMEOUT_EN
               tmr_q <= '0;
`endif
               estado_q <= fin_q ? FIN : ESPERA;
            end
            FIN: begin
               if (ev_s[1]) begin
                  tablero_q     <= 18'd0;
                  movimientos_q <= 4'd0;
                  ganador_q     <= 2'b00;
                  jugador_q     <= 1'b0;
                  casilla_q     <= 4'd0;
                  fin_q         <= 1'b0;
                  estado_q      <= ESPERA;
`ifdef TURN_TIMEOUT_EN
                  tmr_q         <= '0;
`endif
               end else begin
                  estado_q <= FIN;
               end
            end
            default: begin
               estado_q <= ESPERA;
            end
         endcase
      end
   end

   assign casilla_sel   = casilla_q;
   assign tablero       = tablero_q;
   assign jugador       = jugador_q;
   assign movimientos   = movimientos_q;
   assign ganador       = ganador_q;
   assign fin_juego     = fin_q;
   assign error_ocupada = error_q;
`ifdef TURN_TIMEOUT_EN
   assign timeout       = timeout_q;
`else
   localparam logic SIN_TEMPORIZADOR = (TIMEOUT_CYCLES > 0) ? 1'b0 : 1'b0;
   assign timeout       = SIN_TEMPORIZADOR;
`endif

endmodule

// File: tb/tb_controlador_turnos_tablero.sv
// Directed bench for controlador_turnos_tablero (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
`timescale 1ns/1ps
module tb_controlador_turnos_tablero;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        boton_mover = 1'b1;
   logic        boton_confirmar = 1'b1;
   logic [3:0]  casilla_sel;
   logic [17:0] tablero;
   logic        jugador;
   logic [3:0]  movimientos;
   logic [1:0]  ganador;
   logic        fin_juego;
   logic        error_ocupada;
   logic        timeout;

   int n_chk = 0;
   int n_fail = 0;
   int err_cnt = 0;
   int to_cnt = 0;
   int cur = 0;

   controlador_turnos_tablero #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .boton_mover(boton_mover), .boton_confirmar(boton_confirmar),
      .casilla_sel(casilla_sel), .tablero(tablero), .jugador(jugador), .movimientos(movimientos),
      .ganador(ganador), .fin_juego(fin_juego), .error_ocupada(error_ocupada), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ciclos(input int n);
      repeat (n) begin
         @(negedge clk);
         if (error_ocupada) err_cnt++;
         if (timeout) to_cnt++;
      end
   endtask

   task automatic pulsar(input logic m, input logic c);
      err_cnt = 0;
      to_cnt = 0;
      boton_mover = ~m;
      boton_confirmar = ~c;
      ciclos(10);
      boton_mover = 1'b1;
      boton_confirmar = 1'b1;
      ciclos(10);
   endtask

   task automatic ir_a(input int k);
      repeat ((k - cur + 9) % 9) pulsar(1'b1, 1'b0);
      cur = k;
   endtask

   int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
   int k;
   int m;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_casilla", casilla_sel, 0);
      check("reset_tablero", tablero, 0);
      check("reset_jugador", jugador, 0);
      check("reset_movs", movimientos, 0);
      check("reset_ganador", ganador, 0);
      check("reset_fin", fin_juego, 0);
      check("reset_error", error_ocupada, 0);
      check("reset_timeout", timeout, 0);
      rst = 1'b1;
      ciclos(3);

      for (int i = 1; i <= 10; i++) begin
         pulsar(1'b1, 1'b0);
         check("cursor_paso", casilla_sel, i % 9);
      end
      cur = 1;
      boton_mover = 1'b0;
      ciclos(2);
      boton_mover = 1'b1;
      ciclos(10);
      check("glitch_sin_cambio", casilla_sel, 1);

      ir_a(0);
      pulsar(1'b0, 1'b1);
      check("p1_celda0", tablero, 18'h00001);
      check("p1_jugador", jugador, 1);
      check("p1_movs", movimientos, 1);
      ir_a(3);
      pulsar(1'b0, 1'b1);
      check("p2_celda3", tablero, 18'h00081);
      check("p2_jugador", jugador, 0);
      pulsar(1'b0, 1'b1);
      check("ocupada_pulso", err_cnt, 1);
      check("ocupada_jugador", jugador, 0);
      check("ocupada_celda3", tablero[7:6], 2'b10);
      check("ocupada_movs", movimientos, 2);

      ir_a(1);
      pulsar(1'b0, 1'b1);
      ir_a(4);
      pulsar(1'b0, 1'b1);
      ir_a(2);
      pulsar(1'b0, 1'b1);
      check("gana_ganador", ganador, 2'b01);
      check("gana_fin", fin_juego, 1);
      check("gana_movs", movimientos, 5);
      check("gana_tablero", tablero, 18'h00295);
      check("gana_jugador", jugador, 0);
      pulsar(1'b1, 1'b0);
      check("fin_cursor_quieto", casilla_sel, 2);
      check("fin_sigue", fin_juego, 1);
      pulsar(1'b0, 1'b1);
      check("limpia_tablero", tablero, 0);
      check("limpia_jugador", jugador, 0);
      check("limpia_casilla", casilla_sel, 0);
      check("limpia_movs", movimientos, 0);
      check("limpia_ganador", ganador, 0);
      check("limpia_fin", fin_juego, 0);
      cur = 0;

      for (int i = 0; i < 9; i++) begin
         ir_a(seq[i]);
         pulsar(1'b0, 1'b1);
      end
      check("empate_movs", movimientos, 9);
      check("empate_ganador", ganador, 2'b11);
      check("empate_fin", fin_juego, 1);
      check("empate_tablero", tablero, 18'h16A59);
      pulsar(1'b0, 1'b1);
      check("empate_limpia_tablero", tablero, 0);
      check("empate_limpia_jugador", jugador, 0);
      cur = 0;

      ir_a(5);
      pulsar(1'b1, 1'b1);
      check("doble_tablero", tablero, 18'h00400);
      check("doble_casilla", casilla_sel, 5);
      check("doble_movs", movimientos, 1);
      check("doble_jugador", jugador, 1);

`ifdef TURN_TIMEOUT_EN
      k = 0;
      while (!timeout && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("to_primero_visto", (k < 200) ? 32'd1 : 32'd0, 1);
      check("to_jugador", jugador, 0);
      check("to_tablero", tablero, 18'h00400);
      check("to_movs", movimientos, 1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!timeout && k < 200);
      check("to_periodo", k, 64);
      check("to_jugador2", jugador, 1);
      to_cnt = 0;
      repeat (54) @(negedge clk);
      boton_mover = 1'b0;
      k = 0;
      while (casilla_sel == 4'd5 && k < 40) begin
         @(negedge clk);
         if (timeout) to_cnt++;
         k++;
      end
      check("to_mover_casilla", casilla_sel, 6);
      check("to_sin_pulso", to_cnt, 0);
      m = 0;
      while (!timeout && m < 200) begin
         @(negedge clk);
         m++;
         if (m == 10) boton_mover = 1'b1;
      end
      boton_mover = 1'b1;
      check("to_tras_mover", m, 64);
      cur = 6;
`else
      to_cnt = 0;
      ciclos(100);
      check("sin_timeout", to_cnt, 0);
      check("sin_timeout_jugador", jugador, 1);
`endif

      ir_a(6);
      boton_confirmar = 1'b0;
      k = 0;
      while (movimientos == 4'd1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("escribe_alcanzado", movimientos, 2);
      rst = 1'b0;
      #1;
      check("rst_tablero", tablero, 0);
      check("rst_casilla", casilla_sel, 0);
      check("rst_movs", movimientos, 0);
      check("rst_estado", 32'(dut.estado_q), 0);
      boton_confirmar = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      ciclos(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
